fetch_sequencer: RTL and testbench

- Multi-cycle instruction fetch controller for the single-ported, byte-wide code memory.
- Issues four sequential byte reads per instruction and assembles them big-endian (byte at pc is inst[31:24]).
- Presents the word to the execute stage with a valid/ready handshake.
- Handles branch redirects from execute (taken B.cond, B, CBZ/TBZ, BR) by aborting or discarding the current fetch.

---
 rtl/fetch_sequencer.sv | 113 +++++++++++
 tb/tb_fetch_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction fetch: four byte reads assembled big-endian, valid/ready to execute.
// Optional FETCH_ALIGN_CHECK_EN traps misaligned redirects in a sticky FAULT state.
module fetch_sequencer #(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              busy,
  output logic              fault
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_VALID = 2'd2;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam logic [1:0] S_FAULT = 2'd3;
`endif

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [1:0]        r_byte_cnt;
  logic [31:0]       r_partial;
  logic [31:0]       r_inst;
  logic [1:0]        w_redirect_state;

`ifdef FETCH_ALIGN_CHECK_EN
  assign w_redirect_state = (redirect_pc[1:0] != 2'b00) ? S_FAULT : S_FETCH;
  assign fault            = (r_state == S_FAULT);
`else
  assign w_redirect_state = S_FETCH;
  assign fault            = 1'b0;
`endif

  assign mem_rd     = (r_state == S_FETCH);
  assign mem_addr   = mem_rd ? (r_pc + ADDR_W'(r_byte_cnt)) : r_pc;
  assign inst       = r_inst;
  assign inst_pc    = r_pc;
  assign inst_valid = (r_state == S_VALID);
  assign busy       = (r_state != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_byte_cnt <= 2'd0;
      r_partial  <= 32'd0;
      r_inst     <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (redirect) begin
            r_pc       <= redirect_pc;
            r_byte_cnt <= 2'd0;
            r_state    <= w_redirect_state;
          end else if (start) begin
            r_byte_cnt <= 2'd0;
            r_state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (redirect) begin
            r_pc       <= redirect_pc;
            r_byte_cnt <= 2'd0;
            r_state    <= w_redirect_state;
          end else begin
            case (r_byte_cnt)
              2'd0: r_partial[31:24] <= mem_data;
              2'd1: r_partial[23:16] <= mem_data;
              2'd2: r_partial[15:8]  <= mem_data;
              default: r_partial[7:0] <= mem_data;
            endcase
            // inst is only updated once the final byte arrives, never with a partial word.
            if (r_byte_cnt == 2'd3) begin
              r_inst     <= {r_partial[31:8], mem_data};
              r_byte_cnt <= 2'd0;
              r_state    <= S_VALID;
            end else begin
              r_byte_cnt <= r_byte_cnt + 2'd1;
            end
          end
        end
        S_VALID: begin
          if (redirect) begin
            r_pc       <= redirect_pc;
            r_byte_cnt <= 2'd0;
            r_state    <= w_redirect_state;
          end else if (inst_ready) begin
            r_pc       <= r_pc + ADDR_W'(4);
            r_byte_cnt <= 2'd0;
            r_state    <= S_FETCH;
          end
        end
        default: begin
          // FAULT is sticky: only reset leaves it.
          r_state <= r_state;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer against a byte-wide code memory model.
// Misaligned-redirect expectations follow FETCH_ALIGN_CHECK_EN.
`timescale 1ns/1ps
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [63:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        busy;
  logic        fault;

  logic [7:0] mem [0:511];
  int checks;
  int failures;

  fetch_sequencer #(.ADDR_W(64), .RESET_PC(64'd0)) dut (
    .clk(clk), .reset(reset), .start(start),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .busy(busy), .fault(fault)
  );

  assign mem_data = mem[mem_addr[8:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs are driven and outputs sampled 1ns after it.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    step(2);
    chk64("rst_inst_valid", 64'(inst_valid), 64'd0);
    chk64("rst_mem_rd",     64'(mem_rd),     64'd0);
    chk64("rst_busy",       64'(busy),       64'd0);
    chk64("rst_fault",      64'(fault),      64'd0);
    chk64("rst_mem_addr",   mem_addr,        64'd0);
    chk64("rst_inst",       64'(inst),       64'd0);
    reset = 1'b0;
    step(2);
    chk64("idle_busy", 64'(busy), 64'd0);
  endtask

  task automatic test_first_fetch();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int b = 0; b < 4; b++) begin
      chk64("fetch1_mem_rd",   64'(mem_rd), 64'd1);
      chk64("fetch1_mem_addr", mem_addr,    64'(b));
      chk64("fetch1_no_valid", 64'(inst_valid), 64'd0);
      step();
    end
    chk64("fetch1_valid",   64'(inst_valid), 64'd1);
    chk64("fetch1_inst",    64'(inst),       64'h8B020041);
    chk64("fetch1_inst_pc", inst_pc,         64'd0);
  endtask

  task automatic test_stall_and_advance();
    for (int c = 0; c < 3; c++) begin
      step();
      chk64("stall_valid",   64'(inst_valid), 64'd1);
      chk64("stall_inst",    64'(inst),       64'h8B020041);
      chk64("stall_inst_pc", inst_pc,         64'd0);
      chk64("stall_mem_rd",  64'(mem_rd),     64'd0);
    end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk64("adv_mem_rd",   64'(mem_rd), 64'd1);
    chk64("adv_mem_addr", mem_addr,    64'd4);
    chk64("adv_inst_pc",  inst_pc,     64'd4);
  endtask

  task automatic test_redirect_mid_fetch();
    step(2);
    chk64("redir_pre_addr", mem_addr, 64'd6);
    redirect = 1'b1; redirect_pc = 64'h40;
    step();
    redirect = 1'b0;
    chk64("redir_mem_addr", mem_addr, 64'h40);
    chk64("redir_no_valid", 64'(inst_valid), 64'd0);
    step(4);
    chk64("redir_valid",   64'(inst_valid), 64'd1);
    chk64("redir_inst",    64'(inst),       64'hDEADBEEF);
    chk64("redir_inst_pc", inst_pc,         64'h40);
  endtask

  task automatic test_redirect_beats_ready();
    redirect = 1'b1; redirect_pc = 64'h8;
    step();
    redirect = 1'b0;
    step(4);
    chk64("pc8_valid", 64'(inst_valid), 64'd1);
    chk64("pc8_inst",  64'(inst),       64'hD65F03C0);
    chk64("pc8_pc",    inst_pc,         64'h8);
    redirect = 1'b1; redirect_pc = 64'h100; inst_ready = 1'b1;
    step();
    redirect = 1'b0; inst_ready = 1'b0;
    chk64("win_inst_pc",  inst_pc,           64'h100);
    chk64("win_mem_addr", mem_addr,          64'h100);
    chk64("win_no_valid", 64'(inst_valid),   64'd0);
    step(4);
    chk64("win_inst", 64'(inst), 64'hA1B2C3D4);
  endtask

  task automatic test_back_to_back();
    int edges;
    inst_ready = 1'b1;
    edges = 0;
    step();
    edges++;
    while (!inst_valid && edges < 20) begin
      step();
      edges++;
    end
    chk64("b2b_period",  64'(edges), 64'd5);
    chk64("b2b_inst_pc", inst_pc,    64'h104);
    chk64("b2b_inst",    64'(inst),  64'h55667788);
    inst_ready = 1'b0;
  endtask

  task automatic test_pc_wrap();
    redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    redirect = 1'b0;
    step(3);
    chk64("wrap_last_addr", mem_addr, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    chk64("wrap_inst", 64'(inst), 64'hCAFEF00D);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk64("wrap_pc",       inst_pc,  64'd0);
    chk64("wrap_mem_addr", mem_addr, 64'd0);
  endtask

  task automatic test_async_reset();
    step();
    chk64("areset_pre_addr", mem_addr, 64'd1);
    chk64("areset_pre_busy", 64'(busy), 64'd1);
    #3;
    reset = 1'b1;
    #1;
    chk64("areset_inst_valid", 64'(inst_valid), 64'd0);
    chk64("areset_mem_rd",     64'(mem_rd),     64'd0);
    chk64("areset_busy",       64'(busy),       64'd0);
    chk64("areset_mem_addr",   mem_addr,        64'd0);
    chk64("areset_inst",       64'(inst),       64'd0);
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_misaligned();
    redirect = 1'b1; redirect_pc = 64'h42;
    step();
    redirect = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    chk64("mis_fault",   64'(fault),      64'd1);
    chk64("mis_busy",    64'(busy),       64'd1);
    chk64("mis_mem_rd",  64'(mem_rd),     64'd0);
    chk64("mis_pc",      inst_pc,         64'h42);
    start = 1'b1; redirect = 1'b1; redirect_pc = 64'h80; inst_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk64("mis_sticky_fault", 64'(fault),      64'd1);
      chk64("mis_sticky_rd",    64'(mem_rd),     64'd0);
      chk64("mis_sticky_valid", 64'(inst_valid), 64'd0);
    end
    start = 1'b0; redirect = 1'b0; inst_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk64("mis_reset_fault", 64'(fault), 64'd0);
    step();
    reset = 1'b0;
`else
    chk64("mis_fault",    64'(fault),  64'd0);
    chk64("mis_mem_addr", mem_addr,    64'h42);
    chk64("mis_mem_rd",   64'(mem_rd), 64'd1);
    step(3);
    chk64("mis_last_addr", mem_addr, 64'h45);
    step();
    chk64("mis_valid",   64'(inst_valid), 64'd1);
    chk64("mis_inst",    64'(inst),       64'hBEEF1234);
    chk64("mis_inst_pc", inst_pc,         64'h42);
`endif
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    {mem[0],     mem[1],     mem[2],     mem[3]}     = 32'h8B020041;
    {mem[4],     mem[5],     mem[6],     mem[7]}     = 32'h11223344;
    {mem[8],     mem[9],     mem[10],    mem[11]}    = 32'hD65F03C0;
    {mem[9'h40], mem[9'h41], mem[9'h42], mem[9'h43]} = 32'hDEADBEEF;
    {mem[9'h44], mem[9'h45]}                         = 16'h1234;
    {mem[9'h100], mem[9'h101], mem[9'h102], mem[9'h103]} = 32'hA1B2C3D4;
    {mem[9'h104], mem[9'h105], mem[9'h106], mem[9'h107]} = 32'h55667788;
    {mem[9'h1FC], mem[9'h1FD], mem[9'h1FE], mem[9'h1FF]} = 32'hCAFEF00D;

    test_reset();
    test_first_fetch();
    test_stall_and_advance();
    test_redirect_mid_fetch();
    test_redirect_beats_ready();
    test_back_to_back();
    test_pc_wrap();
    test_async_reset();
    test_misaligned();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
